// File: rtl/frogger_pkg.sv
// Shared direction type and HID keycode constants for the frog/ball move path.
package frogger_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_UARR  = 8'h52;
    localparam logic [7:0] KEY_DARR  = 8'h51;
    localparam logic [7:0] KEY_LARR  = 8'h50;
    localparam logic [7:0] KEY_RARR  = 8'h4F;

    function automatic dir_t decode_key(input logic [7:0] key);
        dir_t d;
        case (key)
            KEY_W,  KEY_UARR: d = DIR_UP;
            KEY_S,  KEY_DARR: d = DIR_DOWN;
            KEY_A,  KEY_LARR: d = DIR_LEFT;
            KEY_D,  KEY_RARR: d = DIR_RIGHT;
            default:          d = DIR_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small synchronous FIFO of pending moves; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module move_fifo
    import frogger_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  dir_t                       din,
    output dir_t                       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    dir_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/move_cmd_gen.sv
// HID keycode to one-frame direction commands, one hop per press, buffered per frame.
// Optional auto-repeat of held keys when AUTO_REPEAT_EN is defined.
module move_cmd_gen
    import frogger_pkg::*;
#(
    parameter int QUEUE_DEPTH   = 4
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
`endif
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic [7:0]                       keycode,
    input  logic                             frame_tick,
    output logic                             up,
    output logic                             down,
    output logic                             left,
    output logic                             right,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
    output logic                             overflow
);

    typedef enum logic {ST_IDLE, ST_ISSUE} out_state_t;

    dir_t       dir, prev_dir, head;
    out_state_t state;
    logic       press_evt, rpt_push, push, pop, full, empty;

    assign dir       = decode_key(keycode);
    assign press_evt = (dir != DIR_NONE) && (dir != prev_dir);
    // Pop decision uses occupancy before this cycle's push.
    assign pop       = frame_tick && !empty;
    assign push      = press_evt || rpt_push;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) prev_dir <= DIR_NONE;
        else          prev_dir <= dir;
    end

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {RP_HELD_IDLE, RP_DELAY, RP_REPEAT} rpt_state_t;

    rpt_state_t rpt_state;
    logic [7:0] rpt_cnt;
    logic       delay_done, period_done;

    assign delay_done  = (rpt_state == RP_DELAY)  && (rpt_cnt == 8'(REPEAT_DELAY - 1));
    assign period_done = (rpt_state == RP_REPEAT) && (rpt_cnt == 8'(REPEAT_PERIOD - 1));
    assign rpt_push    = frame_tick && !press_evt && (dir != DIR_NONE) && (delay_done || period_done);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rpt_state <= RP_HELD_IDLE;
            rpt_cnt   <= '0;
        end else if (dir == DIR_NONE) begin
            rpt_state <= RP_HELD_IDLE;
            rpt_cnt   <= '0;
        end else if (press_evt) begin
            rpt_state <= RP_DELAY;
            rpt_cnt   <= '0;
        end else if (frame_tick && rpt_state != RP_HELD_IDLE) begin
            if (delay_done || period_done) begin
                rpt_state <= RP_REPEAT;
                rpt_cnt   <= '0;
            end else begin
                rpt_cnt   <= rpt_cnt + 8'd1;
            end
        end
    end
`else
    assign rpt_push = 1'b0;
`endif

    move_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk   (Clk),
        .rst_n (Reset_n),
        .push  (push),
        .pop   (pop),
        .din   (dir),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (queue_count)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) overflow <= 1'b0;
        else          overflow <= push && full && !pop;
    end

    // Output FSM: outputs only move on the cycle after a frame tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
            up    <= 1'b0;
            down  <= 1'b0;
            left  <= 1'b0;
            right <= 1'b0;
        end else if (frame_tick) begin
            if (!empty) begin
                state <= ST_ISSUE;
                up    <= (head == DIR_UP);
                down  <= (head == DIR_DOWN);
                left  <= (head == DIR_LEFT);
                right <= (head == DIR_RIGHT);
            end else begin
                if (state == ST_ISSUE) state <= ST_IDLE;
                up    <= 1'b0;
                down  <= 1'b0;
                left  <= 1'b0;
                right <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_move_cmd_gen.sv
// Directed bench for move_cmd_gen: press/queue/overflow/reset behaviour and held-key repeat.
module tb_move_cmd_gen;

    localparam int GAP = 15;
    localparam logic [3:0] O_NONE = 4'b0000, O_UP = 4'b1000, O_DN = 4'b0100,
                           O_LF = 4'b0010, O_RT = 4'b0001;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       up, down, left, right, overflow;
    logic [2:0] queue_count;
    logic [3:0] outs;

    int n_chk  = 0;
    int n_fail = 0;

    assign outs = {up, down, left, right};

    move_cmd_gen #(.QUEUE_DEPTH(4)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .keycode     (keycode),
        .frame_tick  (frame_tick),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .queue_count (queue_count),
        .overflow    (overflow)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        step(GAP);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    logic [7:0]  keys [6];
    logic [3:0]  exp_o [4];
    logic [40:0] issued;
    logic [40:0] exp_issued;

    initial begin
        keys = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h52, 8'h51};
        exp_o = '{O_DN, O_LF, O_RT, O_RT};

        Reset_n = 1'b0; keycode = 8'h00; frame_tick = 1'b0;
        step(3);
        chk("rst_outs", outs, O_NONE);
        chk("rst_qc", queue_count, 0);
        chk("rst_ovf", overflow, 0);
        Reset_n = 1'b1;
        step(2);

        // 1: held W for 3 frames -> exactly one up hop
        keycode = 8'h1A;
        step(2);
        chk("t1_qc_push", queue_count, 1);
        frame();
        chk("t1_up", outs, O_UP);
        chk("t1_qc_pop", queue_count, 0);
        step(5);
        chk("t1_up_hold", outs, O_UP);
        frame();
        chk("t1_off", outs, O_NONE);
        frame();
        chk("t1_off2", outs, O_NONE);
        keycode = 8'h00;
        frame();
        chk("t1_off3", outs, O_NONE);
        chk("t1_qc_end", queue_count, 0);

        // 2: A,0,D,0,DownArrow within one frame
        keycode = 8'h04; step(2);
        keycode = 8'h00; step(2);
        keycode = 8'h07; step(2);
        keycode = 8'h00; step(2);
        keycode = 8'h51; step(2);
        keycode = 8'h00; step(2);
        chk("t2_qc", queue_count, 3);
        frame(); chk("t2_left", outs, O_LF);  chk("t2_qc2", queue_count, 2);
        frame(); chk("t2_right", outs, O_RT); chk("t2_qc1", queue_count, 1);
        frame(); chk("t2_down", outs, O_DN);  chk("t2_qc0", queue_count, 0);
        frame(); chk("t2_idle", outs, O_NONE);

        // 3: six presses in one frame, depth 4
        for (int i = 0; i < 6; i++) begin
            keycode = keys[i];
            step(1);
            chk($sformatf("t3_ovf_press%0d", i), overflow, (i >= 4) ? 1 : 0);
            keycode = 8'h00;
            step(1);
            chk($sformatf("t3_ovf_clear%0d", i), overflow, 0);
        end
        chk("t3_qc_full", queue_count, 4);
        // push and pop in the same cycle while full: both accepted
        step(GAP);
        keycode = 8'h4F; frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        chk("t3_pp_ovf", overflow, 0);
        chk("t3_pp_qc", queue_count, 4);
        chk("t3_pp_up", outs, O_UP);
        keycode = 8'h00;
        for (int i = 0; i < 4; i++) begin
            frame();
            chk($sformatf("t3_drain%0d", i), outs, exp_o[i]);
            chk($sformatf("t3_drain_qc%0d", i), queue_count, 3 - i);
        end
        frame();
        chk("t3_idle", outs, O_NONE);

        // 4: press coincident with frame_tick, FIFO empty
        step(GAP);
        keycode = 8'h1A; frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        chk("t4_not_yet", outs, O_NONE);
        chk("t4_qc", queue_count, 1);
        frame();
        chk("t4_up", outs, O_UP);
        keycode = 8'h00;
        frame();
        chk("t4_off", outs, O_NONE);

        // 5: reset mid-ISSUE with key held
        keycode = 8'h07;
        step(2);
        frame();
        chk("t5_right", outs, O_RT);
        step(3);
        Reset_n = 1'b0;
        #2;
        chk("t5_rst_outs", outs, O_NONE);
        chk("t5_rst_qc", queue_count, 0);
        step(2);
        Reset_n = 1'b1;
        step(1);
        chk("t5_repress_qc", queue_count, 1);
        frame();
        chk("t5_right2", outs, O_RT);
        frame();
        chk("t5_once", outs, O_NONE);
        keycode = 8'h00;
        step(2);

        // 6: RightArrow held for 40 frames
        keycode = 8'h4F;
        step(2);
        issued = '0;
        for (int f = 1; f <= 40; f++) begin
            frame();
            issued[f] = (outs == O_RT);
        end
`ifdef AUTO_REPEAT_EN
        exp_issued = '0;
        exp_issued[1] = 1'b1; exp_issued[21] = 1'b1;
        exp_issued[29] = 1'b1; exp_issued[37] = 1'b1;
`else
        exp_issued = 41'h2;
`endif
        chk("t6_hold_pattern", issued, exp_issued);
        keycode = 8'h00;
        frame();
        chk("t6_off", outs, O_NONE);
        chk("t6_qc", queue_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
